keyboard_pad_decoder: RTL

KEYBOARD_PAD_DECODER -- requirements
Module: keyboard_pad_decoder

---
 rtl/keyboard_pad_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/keyboard_pad_decoder.sv
// PS/2 keyboard receiver and scan-code decoder that turns W/S and the up/down
// arrow keys into mutually exclusive up/down level outputs for a pad controller.
module keyboard_pad_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up_out,
  output logic       down_out,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_e;

  logic ps2_clk_meta_q,  ps2_clk_meta_d;
  logic ps2_clk_sync_q,  ps2_clk_sync_d;
  logic ps2_clk_prev_q,  ps2_clk_prev_d;
  logic ps2_data_meta_q, ps2_data_meta_d;
  logic ps2_data_sync_q, ps2_data_sync_d;

  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       code_q, code_d;
  logic             code_valid_q, code_valid_d;
  logic             frame_err_q, frame_err_d;

  dec_state_e state_q, state_d;
  logic w_held_q, w_held_d, s_held_q, s_held_d;
  logic au_held_q, au_held_d, ad_held_q, ad_held_d;
  logic up_out_q, up_out_d, down_out_q, down_out_d;

  logic fall_edge;
  logic key_evt, key_ext, key_set;
  logic up_lvl, down_lvl;

  assign fall_edge = ps2_clk_prev_q & ~ps2_clk_sync_q;

  always_comb begin
    ps2_clk_meta_d  = ps2_clk;
    ps2_clk_sync_d  = ps2_clk_meta_q;
    ps2_clk_prev_d  = ps2_clk_sync_q;
    ps2_data_meta_d = ps2_data;
    ps2_data_sync_d = ps2_data_meta_q;
  end

  // Frame receiver: bit index 0 waits for a low start bit, 10 is the stop bit.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_cnt_d    = tmo_cnt_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall_edge) begin
      tmo_cnt_d = '0;
      case (bit_idx_q)
        4'd0: if (!ps2_data_sync_q) bit_idx_d = 4'd1;
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          shift_d   = {ps2_data_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 4'd1;
        end
        4'd9: begin
          parity_d  = ps2_data_sync_q;
          bit_idx_d = 4'd10;
        end
        default: begin
          if ((^{shift_q, parity_q}) && ps2_data_sync_q) begin
            code_d       = shift_q;
            code_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          bit_idx_d = 4'd0;
        end
      endcase
    end else if (bit_idx_q != 4'd0) begin
      if (tmo_cnt_q == TMO_LIMIT) begin
        bit_idx_d   = 4'd0;
        tmo_cnt_d   = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  // Scan decoder: prefixes E0/F0 select which flag a following code touches.
  always_comb begin
    state_d   = state_q;
    key_evt   = 1'b0;
    key_ext   = 1'b0;
    key_set   = 1'b0;
    w_held_d  = w_held_q;
    s_held_d  = s_held_q;
    au_held_d = au_held_q;
    ad_held_d = ad_held_q;
    if (frame_err_q) begin
      state_d = IDLE;
    end else if (code_valid_q) begin
      state_d = IDLE;
      unique case (state_q)
        IDLE: begin
          if (code_q == 8'hE0)      state_d = EXT;
          else if (code_q == 8'hF0) state_d = BRK;
          else begin
            key_evt = 1'b1;
            key_set = 1'b1;
          end
        end
        EXT: begin
          if (code_q == 8'hF0) state_d = EXT_BRK;
          else begin
            key_evt = 1'b1;
            key_ext = 1'b1;
            key_set = 1'b1;
          end
        end
        BRK: key_evt = 1'b1;
        EXT_BRK: begin
          key_evt = 1'b1;
          key_ext = 1'b1;
        end
      endcase
    end
    if (key_evt) begin
      if (!key_ext) begin
        if (code_q == 8'h1D) w_held_d = key_set;
        if (code_q == 8'h1B) s_held_d = key_set;
      end else begin
        if (code_q == 8'h75) au_held_d = key_set;
        if (code_q == 8'h72) ad_held_d = key_set;
      end
    end
    up_lvl     = w_held_d | au_held_d;
    down_lvl   = s_held_d | ad_held_d;
    up_out_d   = up_lvl & ~down_lvl;
    down_out_d = down_lvl & ~up_lvl;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      ps2_clk_meta_q  <= 1'b1;
      ps2_clk_sync_q  <= 1'b1;
      ps2_clk_prev_q  <= 1'b1;
      ps2_data_meta_q <= 1'b1;
      ps2_data_sync_q <= 1'b1;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      parity_q        <= 1'b0;
      tmo_cnt_q       <= '0;
      code_q          <= '0;
      code_valid_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      state_q         <= IDLE;
      w_held_q        <= 1'b0;
      s_held_q        <= 1'b0;
      au_held_q       <= 1'b0;
      ad_held_q       <= 1'b0;
      up_out_q        <= 1'b0;
      down_out_q      <= 1'b0;
    end else begin
      ps2_clk_meta_q  <= ps2_clk_meta_d;
      ps2_clk_sync_q  <= ps2_clk_sync_d;
      ps2_clk_prev_q  <= ps2_clk_prev_d;
      ps2_data_meta_q <= ps2_data_meta_d;
      ps2_data_sync_q <= ps2_data_sync_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      tmo_cnt_q       <= tmo_cnt_d;
      code_q          <= code_d;
      code_valid_q    <= code_valid_d;
      frame_err_q     <= frame_err_d;
      state_q         <= state_d;
      w_held_q        <= w_held_d;
      s_held_q        <= s_held_d;
      au_held_q       <= au_held_d;
      ad_held_q       <= ad_held_d;
      up_out_q        <= up_out_d;
      down_out_q      <= down_out_d;
    end
  end

  assign up_out     = up_out_q;
  assign down_out   = down_out_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule
